// File: rtl/lfsr_sched_pkg.sv
// Shared definitions for the LFSR round-robin scheduler: LFSR width,
// FSM state encoding and the 3-bit Fibonacci LFSR next-state function.
package lfsr_sched_pkg;

    localparam int LFSR_W = 3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Polynomial x^3+x^2+1, period 7; 000 is a lock-up state and never reached.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[1:0], q[2] ^ q[1]};
    endfunction

endpackage

// File: rtl/lfsr3_core.sv
// 3-bit Fibonacci LFSR register. Load wins over step; reset returns to SEED.
module lfsr3_core
    import lfsr_sched_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 3'b111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] lfsr_q;

    // Select the next register value: explicit load, one LFSR step, or hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // State register with asynchronous active-low reset to the seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one 3-bit LFSR between NREQ requesters.
// Each grant issues the current LFSR value and advances the LFSR.
// Optional build macro LFSR_SCHED_FREERUN_EN: when defined the LFSR steps on
// every non-load clock instead of only on grant entry.
module lfsr_rr_sched
    import lfsr_sched_pkg::*;
#(
    parameter int                NREQ = 2,
    parameter logic [LFSR_W-1:0] SEED = 3'b111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [NREQ-1:0]   gnt,
    output logic              rnd_valid,
    output logic [LFSR_W-1:0] rnd,
    output logic [LFSR_W-1:0] lfsr_q,
    output logic              seed_err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NREQ - 1);

    state_t            state_d, state_q;
    logic [PTR_W-1:0]  ptr_d, ptr_q;
    logic [NREQ-1:0]   gnt_d, gnt_q;
    logic              rnd_valid_d, rnd_valid_q;
    logic [LFSR_W-1:0] rnd_d, rnd_q;
    logic              seed_err_d, seed_err_q;

    logic [PTR_W-1:0]  winner;
    logic              found;
    logic              grant_start;
    logic              lfsr_step;
    logic [LFSR_W-1:0] load_val;

    // Round-robin search: start just after the last winner, first high req wins.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && req[idx]) begin
                winner = PTR_W'(idx);
                found  = 1'b1;
            end
        end
    end

    // A zero seed would lock the LFSR, so substitute SEED and flag it.
    assign load_val = (seed == '0) ? SEED : seed;

    // Next-state and output logic; a seed load blocks a new grant in IDLE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        rnd_valid_d = 1'b0;
        rnd_d       = rnd_q;
        seed_err_d  = seed_load && (seed == '0);
        grant_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found && !seed_load) begin
                    grant_start   = 1'b1;
                    state_d       = S_GRANT;
                    ptr_d         = winner;
                    gnt_d[winner] = 1'b1;
                    rnd_valid_d   = 1'b1;
                    rnd_d         = lfsr_q;
                end
            end
            S_GRANT: begin
                // req is ignored here so a requester can drop it after seeing gnt.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef LFSR_SCHED_FREERUN_EN
    assign lfsr_step = !seed_load;
`else
    assign lfsr_step = grant_start;
`endif

    // FSM, pointer and output registers; reset clears outputs asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= PTR_RST;
            gnt_q       <= '0;
            rnd_valid_q <= 1'b0;
            rnd_q       <= '0;
            seed_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_q       <= rnd_d;
            seed_err_q  <= seed_err_d;
        end
    end

    lfsr3_core #(
        .SEED(SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (seed_load),
        .load_val(load_val),
        .step    (lfsr_step),
        .q       (lfsr_q)
    );

    assign gnt       = gnt_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd       = rnd_q;
    assign seed_err  = seed_err_q;

endmodule

// File: tb/tb_lfsr_rr_sched.sv
// Table-driven bench for lfsr_rr_sched (NREQ=2, SEED=111, default build).
module tb_lfsr_rr_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic       seed_load;
    logic [2:0] seed;
    logic [1:0] gnt;
    logic       rnd_valid;
    logic [2:0] rnd;
    logic [2:0] lfsr_q;
    logic       seed_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lfsr_rr_sched #(
        .NREQ(2),
        .SEED(3'b111)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .seed_load(seed_load),
        .seed     (seed),
        .gnt      (gnt),
        .rnd_valid(rnd_valid),
        .rnd      (rnd),
        .lfsr_q   (lfsr_q),
        .seed_err (seed_err)
    );

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       sl;
        logic [2:0] seed;
        logic [1:0] gnt;
        logic       rv;
        logic [2:0] rnd;
        logic [2:0] lfsr;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] r, input logic sl,
                       input logic [2:0] sd, input logic [1:0] g, input logic rv,
                       input logic [2:0] rn, input logic [2:0] lf, input logic er);
        vec_t v;
        v.rst = rst; v.req = r; v.sl = sl; v.seed = sd;
        v.gnt = g; v.rv = rv; v.rnd = rn; v.lfsr = lf; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [1:0] g,
                           input logic rv, input logic [2:0] rn, input logic [2:0] lf,
                           input logic er);
        $display("%s %0d: gnt=%b rnd_valid=%b rnd=%b lfsr_q=%b seed_err=%b",
                 tag, idx, gnt, rnd_valid, rnd, lfsr_q, seed_err);
        chk({tag, "_gnt"},       idx, 8'(gnt),       8'(g));
        chk({tag, "_rnd_valid"}, idx, 8'(rnd_valid), 8'(rv));
        chk({tag, "_rnd"},       idx, 8'(rnd),       8'(rn));
        chk({tag, "_lfsr_q"},    idx, 8'(lfsr_q),    8'(lf));
        chk({tag, "_seed_err"},  idx, 8'(seed_err),  8'(er));
    endtask

    initial begin
        reset     = 1'b0;
        req       = 2'b00;
        seed_load = 1'b0;
        seed      = 3'b000;

        //  rst req  sl seed  gnt  rv rnd   lfsr  err
        // Reset, then two single grants to requester 0.
        add(1, 2'b00, 0, 3'b000, 2'b00, 0, 3'b000, 3'b111, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b111, 3'b110, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b111, 3'b110, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b110, 3'b100, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b110, 3'b100, 0);
        // Reset, then both requesting for 8 cycles: alternate 0,1,0,1.
        add(1, 2'b00, 0, 3'b000, 2'b00, 0, 3'b000, 3'b111, 0);
        add(0, 2'b11, 0, 3'b000, 2'b01, 1, 3'b111, 3'b110, 0);
        add(0, 2'b11, 0, 3'b000, 2'b00, 0, 3'b111, 3'b110, 0);
        add(0, 2'b11, 0, 3'b000, 2'b10, 1, 3'b110, 3'b100, 0);
        add(0, 2'b11, 0, 3'b000, 2'b00, 0, 3'b110, 3'b100, 0);
        add(0, 2'b11, 0, 3'b000, 2'b01, 1, 3'b100, 3'b001, 0);
        add(0, 2'b11, 0, 3'b000, 2'b00, 0, 3'b100, 3'b001, 0);
        add(0, 2'b11, 0, 3'b000, 2'b10, 1, 3'b001, 3'b010, 0);
        add(0, 2'b11, 0, 3'b000, 2'b00, 0, 3'b001, 3'b010, 0);
        // Seven single grants: full period, 011 wraps to 111, never 000.
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b010, 3'b101, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b010, 3'b101, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b101, 3'b011, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b101, 3'b011, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b011, 3'b111, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b011, 3'b111, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b111, 3'b110, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b111, 3'b110, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b110, 3'b100, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b110, 3'b100, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b100, 3'b001, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b100, 3'b001, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b001, 3'b010, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b001, 3'b010, 0);
        // Seed load 101 with req[1]: no grant, then grant 1 with rnd 101.
        add(0, 2'b10, 1, 3'b101, 2'b00, 0, 3'b001, 3'b101, 0);
        add(0, 2'b10, 0, 3'b000, 2'b10, 1, 3'b101, 3'b011, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b101, 3'b011, 0);
        // Zero seed: SEED substituted, seed_err one cycle, LFSR keeps running.
        add(0, 2'b00, 1, 3'b000, 2'b00, 0, 3'b101, 3'b111, 1);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b101, 3'b111, 0);
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b111, 3'b110, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b111, 3'b110, 0);
        // Seed load during GRANT: loads without stepping, grant already issued.
        add(0, 2'b01, 0, 3'b000, 2'b01, 1, 3'b110, 3'b100, 0);
        add(0, 2'b00, 1, 3'b011, 2'b00, 0, 3'b110, 3'b011, 0);
        add(0, 2'b00, 0, 3'b000, 2'b00, 0, 3'b110, 3'b011, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst ? 1'b0 : 1'b1;
            req       = vecs[i].req;
            seed_load = vecs[i].sl;
            seed      = vecs[i].seed;
            @(negedge clk);
            chk_all("vec", i, vecs[i].gnt, vecs[i].rv, vecs[i].rnd, vecs[i].lfsr, vecs[i].err);
        end

        // Reset during a GRANT cycle: outputs clear asynchronously, ptr returns
        // to NREQ-1 so requester 0 wins next even though it won last.
        seed_load = 1'b0;
        req = 2'b01;
        @(negedge clk);
        chk_all("rstseq", 0, 2'b01, 1'b1, 3'b011, 3'b111, 1'b0);
        req = 2'b00;
        @(negedge clk);
        req = 2'b01;
        @(posedge clk);
        #2;
        chk_all("rstseq", 1, 2'b01, 1'b1, 3'b111, 3'b110, 1'b0);
        reset = 1'b0;
        #1;
        chk_all("rstseq", 2, 2'b00, 1'b0, 3'b000, 3'b111, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b11;
        @(negedge clk);
        chk_all("rstseq", 3, 2'b01, 1'b1, 3'b111, 3'b110, 1'b0);
        req = 2'b00;
        @(negedge clk);
        chk_all("rstseq", 4, 2'b00, 1'b0, 3'b111, 3'b110, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
